// File: rtl/dsm_pkg.sv
// Types and widths shared across the DSM transmit chain.
// The step word layout is fixed by the NCO phase accumulator: 8 integer bits and 24 fractional bits.
package dsm_pkg;

    localparam int ACC_FRAC_WIDTH_DEF = 24;
    localparam int ACC_INT_WIDTH_DEF  = 8;
    localparam int STEP_W             = ACC_FRAC_WIDTH_DEF + ACC_INT_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        DWELL,
        ADVANCE,
        FINISH
    } sweep_state_e;

    typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter that flags when it reaches zero.
// Latency: a load or decrement shows up on zero one cycle later.
// Backpressure: none; it counts only when dec is asserted.
module sweep_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_gen.sv
// Frequency-sweep sequencer that feeds NCO phase-step words (start..stop by delta, with dwell); NCO_SWEEP_TRIANGLE_EN selects a triangular sweep.
// Latency: the first word is valid 1 cycle after start; with tready high, each following word is valid dwell+2 cycles after a handshake.
// Backpressure: a word is held stable until tready; abort may withdraw tvalid without a handshake.
module nco_sweep_gen
    import dsm_pkg::*;
#(
    parameter int ACC_FRAC_WIDTH = 24,
    parameter int ACC_INT_WIDTH  = 8,
    parameter int DWELL_WIDTH    = 16
) (
    input  logic                                    aclk,
    input  logic                                    arst,
    input  logic [ACC_FRAC_WIDTH+ACC_INT_WIDTH-1:0] cfg_start_step,
    input  logic [ACC_FRAC_WIDTH+ACC_INT_WIDTH-1:0] cfg_stop_step,
    input  logic [ACC_FRAC_WIDTH+ACC_INT_WIDTH-1:0] cfg_delta,
    input  logic [DWELL_WIDTH-1:0]                  cfg_dwell,
    input  logic                                    cfg_repeat,
    input  logic                                    start,
    input  logic                                    abort,
    output logic [ACC_FRAC_WIDTH+ACC_INT_WIDTH-1:0] m_axis_data_tdata,
    output logic                                    m_axis_data_tvalid,
    input  logic                                    m_axis_data_tready,
    output logic                                    busy,
    output logic                                    done
);

    localparam int W = ACC_FRAC_WIDTH + ACC_INT_WIDTH;

    sweep_state_e           state_q, state_d;
    logic [W-1:0]           cur_q, cur_d;
    logic [W-1:0]           start_q, stop_q, delta_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   repeat_q;
    logic                   latch_cfg, tmr_load, tmr_dec, tmr_zero;
    logic                   tvalid_q, busy_q, done_q;
    logic [W:0]             up_sum;
    logic [W-1:0]           up_next;

    // The extra top bit catches wrap-around so the sweep saturates at stop instead.
    assign up_sum  = {1'b0, cur_q} + {1'b0, delta_q};
    assign up_next = (up_sum[W] || (up_sum[W-1:0] > stop_q)) ? stop_q : up_sum[W-1:0];

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic         dir_q, dir_d;
    logic [W:0]   dn_diff, rs_sum;
    logic [W-1:0] dn_next, rs_next;

    assign dn_diff = {1'b0, cur_q} - {1'b0, delta_q};
    assign dn_next = (dn_diff[W] || (dn_diff[W-1:0] < start_q)) ? start_q : dn_diff[W-1:0];
    // A repeat resumes the ascent one step above start; start was just emitted at the bottom.
    assign rs_sum  = {1'b0, start_q} + {1'b0, delta_q};
    assign rs_next = (rs_sum[W] || (rs_sum[W-1:0] > stop_q)) ? stop_q : rs_sum[W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        latch_cfg = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
        dir_d     = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    latch_cfg = 1'b1;
                    cur_d     = cfg_start_step;
                    state_d   = EMIT;
`ifdef NCO_SWEEP_TRIANGLE_EN
                    dir_d     = 1'b0;
`endif
                end
            end
            EMIT: begin
                if (m_axis_data_tready) begin
                    if (dwell_q == '0) begin
                        state_d = ADVANCE;
                    end else begin
                        state_d  = DWELL;
                        tmr_load = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (tmr_zero) begin
                    state_d = ADVANCE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ADVANCE: begin
                state_d = EMIT;
`ifdef NCO_SWEEP_TRIANGLE_EN
                if ((delta_q == '0) || ((cur_q >= stop_q) && (cur_q <= start_q)) ||
                    (dir_q && (cur_q <= start_q))) begin
                    if (repeat_q) begin
                        dir_d = 1'b0;
                        cur_d = dir_q ? rs_next : start_q;
                    end else begin
                        state_d = FINISH;
                    end
                end else if (!dir_q && (cur_q < stop_q)) begin
                    cur_d = up_next;
                end else begin
                    dir_d = 1'b1;
                    cur_d = dn_next;
                end
`else
                if ((cur_q >= stop_q) || (delta_q == '0)) begin
                    if (repeat_q) begin
                        cur_d = start_q;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    cur_d = up_next;
                end
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Loaded with dwell-1 so that DWELL occupies exactly dwell cycles before reaching zero.
    sweep_dwell_timer #(
        .WIDTH(DWELL_WIDTH)
    ) u_dwell (
        .aclk    (aclk),
        .arst    (arst),
        .load    (tmr_load),
        .load_val(dwell_q - DWELL_WIDTH'(1)),
        .dec     (tmr_dec),
        .zero    (tmr_zero)
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            delta_q  <= '0;
            dwell_q  <= '0;
            repeat_q <= 1'b0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tvalid_q <= (state_d == EMIT);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == FINISH);
`ifdef NCO_SWEEP_TRIANGLE_EN
            dir_q    <= dir_d;
`endif
            if (latch_cfg) begin
                start_q  <= cfg_start_step;
                stop_q   <= cfg_stop_step;
                delta_q  <= cfg_delta;
                dwell_q  <= cfg_dwell;
                repeat_q <= cfg_repeat;
            end
        end
    end

    assign m_axis_data_tdata  = cur_q;
    assign m_axis_data_tvalid = tvalid_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_nco_sweep_gen.sv
// Randomised bench for nco_sweep_gen: the expected word list comes from plain arithmetic, and beat timing is modelled as dwell+2 gaps.
module tb_nco_sweep_gen;

    logic        aclk = 1'b0;
    logic        arst;
    logic [31:0] cfg_start_step, cfg_stop_step, cfg_delta;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat, start, abort, tready;
    logic [31:0] tdata;
    logic        tvalid, busy, done;

    int vectors = 0;
    int errors  = 0;

    nco_sweep_gen dut (
        .aclk              (aclk),
        .arst              (arst),
        .cfg_start_step    (cfg_start_step),
        .cfg_stop_step     (cfg_stop_step),
        .cfg_delta         (cfg_delta),
        .cfg_dwell         (cfg_dwell),
        .cfg_repeat        (cfg_repeat),
        .start             (start),
        .abort             (abort),
        .m_axis_data_tdata (tdata),
        .m_axis_data_tvalid(tvalid),
        .m_axis_data_tready(tready),
        .busy              (busy),
        .done              (done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Full list of words one pass of a sweep emits.
    function automatic void build_list(input longint s, input longint p, input longint d,
                                       output longint q[$]);
        longint w;
        q = {};
        w = s;
        for (int i = 0; i < 4096; i++) begin
            q.push_back(w);
            if (w >= p || d == 0) break;
            w = (w + d > p) ? p : w + d;
        end
`ifdef NCO_SWEEP_TRIANGLE_EN
        if (d != 0 && s < p) begin
            for (int i = 0; i < 4096 && w > s; i++) begin
                w = (w - d < s) ? s : w - d;
                q.push_back(w);
            end
        end
`endif
    endfunction

    // Reference model: expected outputs for the cycle after each edge.
    logic   m_busy = 1'b0, m_vld = 1'b0, m_done = 1'b0, m_repf = 1'b0;
    longint m_dat = 0;
    int     m_gap = 0, m_dw = 0;
    longint m_q[$], m_rep[$];

    initial forever begin
        @(posedge aclk or posedge arst);
        if (arst) begin
            m_busy = 1'b0; m_vld = 1'b0; m_done = 1'b0; m_dat = 0; m_q = {};
        end else if (!m_busy) begin
            if (start && !abort) begin
                build_list(longint'(cfg_start_step), longint'(cfg_stop_step), longint'(cfg_delta), m_q);
                m_rep = m_q;
`ifdef NCO_SWEEP_TRIANGLE_EN
                if (m_rep.size() > 1) void'(m_rep.pop_front());
`endif
                m_dw   = int'(cfg_dwell);
                m_repf = cfg_repeat;
                m_dat  = m_q.pop_front();
                m_vld  = 1'b1;
                m_busy = 1'b1;
            end
        end else if (abort) begin
            m_busy = 1'b0; m_vld = 1'b0; m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
        end else if (m_vld) begin
            if (tready) begin
                m_vld = 1'b0;
                m_gap = m_dw + 1;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) begin
                if (m_q.size() == 0 && m_repf) m_q = m_rep;
                if (m_q.size() > 0) begin
                    m_dat = m_q.pop_front();
                    m_vld = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    initial forever begin
        @(negedge aclk);
        chk("tvalid", longint'(tvalid), longint'(m_vld));
        chk("busy", longint'(busy), longint'(m_busy));
        chk("done", longint'(done), longint'(m_done));
        if (m_vld) chk("tdata", longint'(tdata), m_dat);
    end

    // Accepted beats, done pulses and handshake-to-next-valid gap.
    longint cap[$];
    int     n_done = 0, cyc = 0, hs_cyc = -1, last_gap = -1;
    logic   prev_v = 1'b0;

    initial forever begin
        @(negedge aclk);
        cyc++;
        if (tvalid && !prev_v && hs_cyc >= 0) last_gap = cyc - hs_cyc;
        if (tvalid && tready) begin
            cap.push_back(longint'(tdata));
            hs_cyc = cyc;
        end
        if (done) n_done++;
        prev_v = tvalid;
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic go(input longint s, input longint p, input longint d, input int dw, input bit rep);
        cfg_start_step = 32'(s);
        cfg_stop_step  = 32'(p);
        cfg_delta      = 32'(d);
        cfg_dwell      = 16'(dw);
        cfg_repeat     = rep;
        start          = 1'b1;
        tick;
        start          = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick;
            n++;
        end
        chk({nm, "_idle_timeout"}, longint'(busy), 0);
    endtask

    task automatic wait_beat(input string nm, input longint want, input int budget);
        int n = 0;
        while (!(tvalid && (want < 0 || longint'(tdata) == want)) && n < budget) begin
            tick;
            n++;
        end
        chk({nm, "_beat_timeout"}, longint'(n >= budget), 0);
    endtask

    task automatic chk_list(input string nm, input longint got[$], input longint exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint l[$];
        longint e[$];
        arst = 1'b1; start = 1'b0; abort = 1'b0; tready = 1'b1;
        cfg_start_step = '0; cfg_stop_step = '0; cfg_delta = '0; cfg_dwell = '0; cfg_repeat = 1'b0;
        repeat (3) tick;
        chk("rst_tdata", longint'(tdata), 0);
        chk("rst_tvalid", longint'(tvalid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        arst = 1'b0;
        tick;

        // Pin the model's word lists with hand-computed sequences.
`ifdef NCO_SWEEP_TRIANGLE_EN
        build_list(100, 120, 10, l); e = '{100, 110, 120, 110, 100}; chk_list("model_tri", l, e);
        build_list(0, 25, 10, l);    e = '{0, 10, 20, 25, 15, 5, 0}; chk_list("model_sat", l, e);
`else
        build_list(100, 130, 10, l); e = '{100, 110, 120, 130};      chk_list("model_saw", l, e);
        build_list(0, 25, 10, l);    e = '{0, 10, 20, 25};           chk_list("model_sat", l, e);
`endif

        // Basic sweep, dwell 0.
        cap.delete(); n_done = 0;
        go(100, 130, 10, 0, 0);
        wait_idle("sweep_a", 100);
        build_list(100, 130, 10, e);
        chk_list("beats_a", cap, e);
        chk("done_a", n_done, 1);
        chk("gap_d0", last_gap, 2);

        // Saturation at stop.
        cap.delete();
        go(0, 25, 10, 0, 0);
        wait_idle("sweep_sat", 100);
        build_list(0, 25, 10, e);
        chk_list("beats_sat", cap, e);

        // Start above stop: single beat then done.
        cap.delete(); n_done = 0;
        go(50, 40, 10, 0, 0);
        wait_idle("sweep_inv", 50);
        e = '{50};
        chk_list("beats_inv", cap, e);
        chk("done_inv", n_done, 1);

`ifdef NCO_SWEEP_TRIANGLE_EN
        cap.delete();
        go(100, 120, 10, 0, 0);
        wait_idle("sweep_tri", 100);
        e = '{100, 110, 120, 110, 100};
        chk_list("beats_tri", cap, e);
`endif

        // Stall on beat 110 for five cycles.
        cap.delete();
        go(100, 130, 10, 0, 0);
        wait_beat("stall", 110, 50);
        tready = 1'b0;
        repeat (5) tick;
        chk("stall_hold", longint'(tdata), 110);
        tready = 1'b1;
        wait_idle("stall", 100);
        build_list(100, 130, 10, e);
        chk_list("beats_stall", cap, e);
        chk("gap_stall", last_gap, 2);

        // Dwell of 3 gives a 5-cycle gap.
        go(100, 130, 10, 3, 0);
        wait_idle("dwell3", 200);
        chk("gap_d3", last_gap, 5);

        // Repeat, then abort during DWELL.
        cap.delete(); n_done = 0;
        go(100, 110, 10, 4, 1);
        repeat (30) tick;
        wait_beat("rep", -1, 20);
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_tvalid", longint'(tvalid), 0);
        repeat (4) tick;
        chk("abort_no_done", n_done, 0);
        while (cap.size() > 4) void'(cap.pop_back());
        e = '{100, 110, 100, 110};
        chk_list("beats_rep", cap, e);

        // Start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", longint'(busy), 0);
        chk("sa_tvalid", longint'(tvalid), 0);

        // Asynchronous reset mid-EMIT.
        go(100, 130, 10, 0, 0);
        wait_beat("to120", 120, 50);
        tready = 1'b0;
        tick;
        #2 arst = 1'b1;
        #1;
        chk("arst_tdata", longint'(tdata), 0);
        chk("arst_tvalid", longint'(tvalid), 0);
        chk("arst_busy", longint'(busy), 0);
        tick;
        arst = 1'b0;
        tready = 1'b1;
        tick;
        cap.delete();
        go(100, 130, 10, 0, 0);
        wait_idle("post_arst", 100);
        build_list(100, 130, 10, e);
        chk_list("beats_post_arst", cap, e);

        // Randomised sweeps with backpressure, stray starts, cfg churn and aborts.
        for (int it = 0; it < 40; it++) begin
            longint s, p, d;
            int     dw, n;
            bit     rep;
            if (it % 8 == 7) begin
                s = longint'(32'hFFFF_FF00) + $urandom_range(0, 128);
                p = longint'(32'hFFFF_FFF0) + $urandom_range(0, 15);
                d = $urandom_range(1, 144);
            end else begin
                s = $urandom_range(0, 200);
                p = $urandom_range(0, 200);
                d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(8, 60);
            end
            dw  = $urandom_range(0, 3);
            rep = ($urandom_range(0, 3) == 0);
            go(s, p, d, dw, rep);
            n = 0;
            while (busy && n < 1000) begin
                tready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) cfg_start_step = $urandom;
                if ($urandom_range(0, 29) == 0) start = 1'b1;
                if ((rep && n == 80) || $urandom_range(0, 199) == 0) abort = 1'b1;
                tick;
                start = 1'b0;
                abort = 1'b0;
                n++;
            end
            chk($sformatf("rand%0d_idle_timeout", it), longint'(busy), 0);
            tready = 1'b1;
            repeat ($urandom_range(1, 3)) tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nco_sweep_gen.md
Name: nco_sweep_gen

Overview:
Frequency-sweep sequencer that sits directly upstream of the I/Q NCO pair in the DSM transmit chain.
- Generates a programmed series of NCO phase-step words: start to stop in fixed increments, holding each for a programmable dwell.
- Delivers each word to the NCO step input over an AXI-Stream-style handshake.
- Runs a sweep once or repeats it continuously, with start/abort control and busy/done status for the JTAG/AXI-Lite control side.

Parameters:
- ACC_FRAC_WIDTH, 24: fractional bits of the NCO phase-step word.
- ACC_INT_WIDTH, 8: integer bits of the NCO phase-step word.
- DWELL_WIDTH, 16: width of the dwell counter, in aclk cycles.

Ports:
- aclk, in, 1: sole clock.
- arst, in, 1: asynchronous, active-high reset.
- cfg_start_step, in, STEP_W: first step word. STEP_W = ACC_FRAC_WIDTH+ACC_INT_WIDTH.
- cfg_stop_step, in, STEP_W: final step word, inclusive.
- cfg_delta, in, STEP_W: increment per point.
- cfg_dwell, in, DWELL_WIDTH: idle cycles between an accepted beat and the next advance.
- cfg_repeat, in, 1: 1 = restart the sweep at cfg_start_step after the stop word.
- start, in, 1: single-cycle start request.
- abort, in, 1: single-cycle abort request.
- m_axis_data_tdata, out, STEP_W: current step word.
- m_axis_data_tvalid, out, 1: step word valid.
- m_axis_data_tready, in, 1: downstream accepts the word.
- busy, out, 1: high whenever state != IDLE.
- done, out, 1: one-cycle pulse when a non-repeating sweep completes.

Behaviour:
- Interface: one clock (aclk); reset arst is asynchronous and active-high.
- Reset values: tdata=0, tvalid=0, busy=0, done=0, state=IDLE, shadow registers=0.
- States are IDLE, EMIT, DWELL, ADVANCE, FINISH. All outputs are registered.
- IDLE + start (abort low):
  - latch all cfg_* into shadow registers;
  - cur=cfg_start_step;
  - move to EMIT; tvalid is high on the cycle after start (latency 1).
- start while busy is ignored. cfg_* changes while busy have no effect.
- EMIT:
  - tvalid=1, tdata=cur, held stable until tready.
  - On the handshake cycle, tvalid drops the next cycle and the FSM enters DWELL loaded with the shadow dwell D.
- DWELL: exactly D cycles, then ADVANCE. D=0 goes straight to ADVANCE.
- ADVANCE (one cycle) is the end-of-sweep test. End-of-sweep is true if cur>=stop, or delta==0.
  - End-of-sweep with repeat=1: cur=start, go to EMIT.
  - End-of-sweep with repeat=0: go to FINISH.
  - Otherwise: next=cur+delta, computed at STEP_W+1 bits. If carry or next>stop, cur=stop (saturate); else cur=next. Go to EMIT.
- Beat spacing with tready=1: next tvalid rises D+2 cycles after a handshake.
- FINISH: done=1 for one cycle, then IDLE. busy falls the same cycle done falls.
- cfg_start_step>cfg_stop_step: the start word is emitted once, then end-of-sweep.
- abort:
  - From any non-IDLE state, next cycle state=IDLE, tvalid=0, busy=0; done is not pulsed.
  - abort is permitted to withdraw tvalid without a handshake; the NCO step input tolerates this.
  - abort beats start when both are asserted in the same cycle.
- arst mid-sweep: all outputs return to reset values immediately.

Optional Feature:
- Macro: NCO_SWEEP_TRIANGLE_EN.
- Defined: the sweep is triangular.
  - After the stop word is emitted, the direction flips and cur decrements by delta, floored at start.
  - The stop word is emitted once at the turnaround.
  - End-of-sweep occurs after the start word is re-emitted. repeat then restarts the ascent without re-emitting start.
  - A direction register is added to shadow state, reset to up.
- Undefined: sawtooth only. No direction register exists.

Decomposition:
- Shared package dsm_pkg holds:
  - the localparam STEP_W;
  - the typedef sweep_state_e {IDLE, EMIT, DWELL, ADVANCE, FINISH};
  - the typedef step_t, logic [STEP_W-1:0], shared with the NCO.
- One sub-module is natural: sweep_dwell_timer, a loadable down-counter with a zero flag.

Test Plan:
- start=100, stop=130, delta=10, dwell=0, tready=1 -> beats 100, 110, 120, 130 spaced 2 cycles apart; done pulses once; busy 0 afterwards.
- start=0, stop=25, delta=10 -> beats 0, 10, 20, 25 (saturation); start=50, stop=40 -> single beat 50, then done.
- tready held low 5 cycles during beat 110 -> tdata stays 110 with tvalid high; the next beat appears 2 cycles after tready rises. Separately, dwell=3 -> 5-cycle handshake-to-tvalid gap.
- repeat=1, start=100, stop=110, delta=10 -> 100, 110, 100, 110, ...; abort during DWELL -> busy=0 and tvalid=0 next cycle, no done; simultaneous start+abort in IDLE -> stays IDLE.
- arst asserted mid-EMIT with tdata=120 -> tdata=0, tvalid=0, busy=0 asynchronously; a fresh start afterwards sweeps normally.
- With NCO_SWEEP_TRIANGLE_EN: start=100, stop=120, delta=10 -> 100, 110, 120, 110, 100, then done.
